// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: 16-bit machine word and 128-bit cache line,
// plus the 16-byte line-alignment helper used by the write-back path.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_line;

  localparam int LINE_OFFSET_BITS = 4;

  function automatic lc3b_word line_align(input lc3b_word addr);
    return {addr[15:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/wb_drain_buffer_line_array.sv
// wb_line_array: address+data storage for the write-back buffer.
// One indexed write port, two combinational read ports, all tags exposed.
module wb_line_array
  import lc3b_types::*;
#(
  parameter int LINE_W = 128,
  parameter int DEPTH  = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  lc3b_word          wr_addr,
  input  logic [LINE_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd0_idx,
  output lc3b_word          rd0_addr,
  output logic [LINE_W-1:0] rd0_data,
  input  logic [IDX_W-1:0]  rd1_idx,
  output logic [LINE_W-1:0] rd1_data,
  output lc3b_word          tag_q [DEPTH]
);

  lc3b_word          addr_mem [DEPTH];
  logic [LINE_W-1:0] data_mem [DEPTH];

  // NOTE: storage is deliberately not reset; validity lives in the pointers/count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      addr_mem[wr_idx] <= wr_addr;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd0_addr = addr_mem[rd0_idx];
  assign rd0_data = data_mem[rd0_idx];
  assign rd1_data = data_mem[rd1_idx];
  assign tag_q    = addr_mem;

endmodule

// File: rtl/wb_drain_buffer.sv
// Write-back drain buffer: 4-entry FIFO of evicted dirty lines drained to pmem.
// Optional store-to-load forwarding port enabled by macro WB_FORWARD_EN.
module wb_drain_buffer
  import lc3b_types::*;
#(
  parameter int LINE_W = $bits(lc3b_c_line),
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_push,
  input  lc3b_word          wb_addr,
  input  logic [LINE_W-1:0] wb_data,
  output logic              wb_full,
  output logic              wb_empty,
  output logic              wb_overflow,
  output logic              pmem_write,
  output lc3b_word          pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  lc3b_word          lookup_addr,
  output logic              lookup_hit,
  output logic [LINE_W-1:0] lookup_data
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state, state_next;
  logic [1:0]        head, tail;
  logic [2:0]        count;
  logic              push_ok, pop;
  logic [1:0]        fwd_idx;
  lc3b_word          head_addr;
  logic [LINE_W-1:0] head_data, fwd_data;
  lc3b_word          tags [DEPTH];

  assign wb_full  = (count == 3'd4);
  assign wb_empty = (count == 3'd0);
  assign push_ok  = wb_push && !wb_full;
  assign pop      = (state == WRITE) && pmem_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      head        <= 2'd0;
      tail        <= 2'd0;
      count       <= 3'd0;
      wb_overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (push_ok) tail <= tail + 2'd1;
      if (pop)     head <= head + 2'd1;
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (wb_push && wb_full) wb_overflow <= 1'b1;
    end
  end

  // NOTE: next-state defaults to holding so no path through this block infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != 3'd0) state_next = WRITE;
      WRITE:   if (pmem_resp)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Head stays put for the whole WRITE, so address/data are stable until the pop.
  assign pmem_write   = (state == WRITE);
  assign pmem_address = line_align(head_addr);
  assign pmem_wdata   = head_data;

  wb_line_array #(.LINE_W(LINE_W), .DEPTH(DEPTH)) u_line_array (
    .clk      (clk),
    .wr_en    (push_ok),
    .wr_idx   (tail),
    .wr_addr  (wb_addr),
    .wr_data  (wb_data),
    .rd0_idx  (head),
    .rd0_addr (head_addr),
    .rd0_data (head_data),
    .rd1_idx  (fwd_idx),
    .rd1_data (fwd_data),
    .tag_q    (tags)
  );

  logic unused_head;
  assign unused_head = ^head_addr[3:0];

`ifdef WB_FORWARD_EN
  // Scan oldest to newest so the youngest matching entry overrides earlier ones.
  always_comb begin
    lookup_hit = 1'b0;
    fwd_idx    = head;
    for (int k = 0; k < DEPTH; k++) begin
      if ((3'(k) < count) && (tags[head + 2'(k)][15:4] == lookup_addr[15:4])) begin
        lookup_hit = 1'b1;
        fwd_idx    = head + 2'(k);
      end
    end
  end

  assign lookup_data = lookup_hit ? fwd_data : '0;

  logic unused_fwd;
  assign unused_fwd = ^{lookup_addr[3:0], tags[0][3:0], tags[1][3:0],
                        tags[2][3:0], tags[3][3:0]};
`else
  assign fwd_idx     = head;
  assign lookup_hit  = 1'b0;
  assign lookup_data = '0;

  logic unused_fwd;
  assign unused_fwd = ^{lookup_addr, fwd_data, tags[0], tags[1], tags[2], tags[3]};
`endif

endmodule

// File: tb/tb_wb_drain_buffer.sv
// Self-checking bench for wb_drain_buffer: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_wb_drain_buffer;
  import lc3b_types::*;

  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wb_push = 1'b0;
  lc3b_word      wb_addr = '0;
  logic [LW-1:0] wb_data = '0;
  logic          pmem_resp = 1'b0;
  lc3b_word      lookup_addr = '0;
  logic          wb_full, wb_empty, wb_overflow, pmem_write, lookup_hit;
  lc3b_word      pmem_address;
  logic [LW-1:0] pmem_wdata, lookup_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_drain_buffer #(.LINE_W(LW), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_push      (wb_push),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_full      (wb_full),
    .wb_empty     (wb_empty),
    .wb_overflow  (wb_overflow),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .lookup_addr  (lookup_addr),
    .lookup_hit   (lookup_hit),
    .lookup_data  (lookup_data)
  );

  // Reference model: an ordered list of held lines plus "a write is outstanding".
  typedef struct {
    lc3b_word      addr;
    logic [LW-1:0] data;
  } ent_t;

  ent_t     mq[$];
  bit       m_busy;
  bit       m_ovf;
  lc3b_word drained[$];

  typedef struct {
    logic     push;
    lc3b_word addr;
    logic     resp;
    logic     e_full;
    logic     e_empty;
    logic     e_write;
    logic     e_ovf;
    lc3b_word e_paddr;
  } vec_t;

  vec_t tv[13];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge(input logic p, input lc3b_word a, input logic [LW-1:0] d,
                            input logic r);
    bit pop_now, push_now;
    ent_t e;
    pop_now  = m_busy && r;
    push_now = p && (mq.size() < 4);
    if (p && !push_now) m_ovf = 1'b1;
    if (m_busy) m_busy = !r;
    else        m_busy = (mq.size() != 0);
    if (pop_now) mq.delete(0);
    if (push_now) begin
      e.addr = a;
      e.data = d;
      mq.push_back(e);
    end
  endtask

  task automatic compare_all(input string tag);
    logic          eh;
    logic [LW-1:0] ed;
    check({tag, ".full"},  wb_full,     mq.size() == 4);
    check({tag, ".empty"}, wb_empty,    mq.size() == 0);
    check({tag, ".write"}, pmem_write,  m_busy);
    check({tag, ".ovf"},   wb_overflow, m_ovf);
    if (m_busy) begin
      check({tag, ".paddr"}, pmem_address, {mq[0].addr[15:4], 4'h0});
      check({tag, ".wdata"}, pmem_wdata,   mq[0].data);
    end
    eh = 1'b0;
    ed = '0;
`ifdef WB_FORWARD_EN
    foreach (mq[i]) begin
      if (mq[i].addr[15:4] == lookup_addr[15:4]) begin
        eh = 1'b1;
        ed = mq[i].data;
      end
    end
`endif
    check({tag, ".hit"},   lookup_hit,  eh);
    check({tag, ".ldata"}, lookup_data, ed);
  endtask

  // Drive one cycle: inputs settle after a falling edge, state is compared at the next one.
  task automatic step(input logic p, input lc3b_word a, input logic [LW-1:0] d,
                      input logic r, input lc3b_word la, input string tag);
    wb_push     = p;
    wb_addr     = a;
    wb_data     = d;
    pmem_resp   = r;
    lookup_addr = la;
    @(posedge clk);
    model_edge(p, a, d, r);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n     = 1'b0;
    wb_push   = 1'b0;
    pmem_resp = 1'b0;
    #1;
    model_reset();
    check({tag, ".rst_write"}, pmem_write,  1'b0);
    check({tag, ".rst_empty"}, wb_empty,    1'b1);
    check({tag, ".rst_full"},  wb_full,     1'b0);
    check({tag, ".rst_ovf"},   wb_overflow, 1'b0);
    check({tag, ".rst_hit"},   lookup_hit,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Answer every write immediately; bounded so a stuck DUT still reaches the summary.
  task automatic drain_all(input string tag);
    int budget;
    budget = 60;
    drained.delete();
    while (mq.size() != 0 && budget > 0) begin
      if (pmem_write) drained.push_back(pmem_address);
      step(1'b0, 16'h0, '0, pmem_write, 16'h0, tag);
      budget--;
    end
    check({tag, ".drained_empty"}, wb_empty, 1'b1);
  endtask

  task automatic check_order(input string tag, input int n,
                             input lc3b_word e0, input lc3b_word e1, input lc3b_word e2);
    lc3b_word exp_a [3];
    exp_a[0] = e0;
    exp_a[1] = e1;
    exp_a[2] = e2;
    check({tag, ".ndrained"}, drained.size(), n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s.order%0d", tag, i), (i < drained.size()) ? drained[i] : 16'hdead,
            exp_a[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] d0, d1, d2;

    // Five pushes with no memory response, then a paced drain.
    tv[0]  = '{1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tv[1]  = '{1'b1, 16'h1110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1000};
    tv[2]  = '{1'b1, 16'h2220, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1000};
    tv[3]  = '{1'b1, 16'h3330, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1000};
    tv[4]  = '{1'b1, 16'h4440, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1000};
    tv[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    tv[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1110};
    tv[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    tv[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2220};
    tv[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    tv[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h3330};
    tv[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000};
    tv[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000};

    do_reset("init");

    for (int i = 0; i < 13; i++) begin
      string t;
      t = $sformatf("tv%0d", i);
      step(tv[i].push, tv[i].addr, {8{tv[i].addr}}, tv[i].resp, 16'h0, t);
      check({t, ".e_full"},  wb_full,     tv[i].e_full);
      check({t, ".e_empty"}, wb_empty,    tv[i].e_empty);
      check({t, ".e_write"}, pmem_write,  tv[i].e_write);
      check({t, ".e_ovf"},   wb_overflow, tv[i].e_ovf);
      if (tv[i].e_write) begin
        check({t, ".e_paddr"}, pmem_address, tv[i].e_paddr);
        check({t, ".e_wdata"}, pmem_wdata,   {8{tv[i].e_paddr}});
      end
    end

    // Single push: WRITE follows, address aligned, pop after the third WRITE cycle.
    do_reset("s033");
    d0 = {$urandom(), $urandom(), $urandom(), $urandom()};
    step(1'b1, 16'h1234, d0, 1'b0, 16'h0, "s033.push");
    check("s033.no_write_yet", pmem_write, 1'b0);
    step(1'b0, 16'h0, '0, 1'b0, 16'h0, "s033.w1");
    check("s033.write", pmem_write, 1'b1);
    check("s033.paddr", pmem_address, 16'h1230);
    check("s033.wdata", pmem_wdata, d0);
    step(1'b0, 16'h0, '0, 1'b0, 16'h0, "s033.w2");
    step(1'b0, 16'h0, '0, 1'b0, 16'h0, "s033.w3");
    check("s033.paddr_stable", pmem_address, 16'h1230);
    step(1'b0, 16'h0, '0, 1'b1, 16'h0, "s033.resp");
    check("s033.empty", wb_empty, 1'b1);
    check("s033.write_done", pmem_write, 1'b0);

    // Full buffer: push and pop on the same edge -> push refused, one popped.
    do_reset("s035");
    step(1'b1, 16'h7001, {8{16'h7001}}, 1'b0, 16'h0, "s035.p0");
    step(1'b1, 16'h711f, {8{16'h711f}}, 1'b0, 16'h0, "s035.p1");
    step(1'b1, 16'h7225, {8{16'h7225}}, 1'b0, 16'h0, "s035.p2");
    step(1'b1, 16'h733a, {8{16'h733a}}, 1'b0, 16'h0, "s035.p3");
    check("s035.full", wb_full, 1'b1);
    step(1'b1, 16'h7440, {8{16'h7440}}, 1'b1, 16'h0, "s035.both");
    check("s035.not_full", wb_full, 1'b0);
    check("s035.ovf", wb_overflow, 1'b1);
    check("s035.not_empty", wb_empty, 1'b0);
    drain_all("s035.drain");
    check_order("s035", 3, 16'h7110, 16'h7220, 16'h7330);

    // Count 2, simultaneous push/pop across pointer wrap 3->0.
    do_reset("s036");
    step(1'b1, 16'h0100, '0, 1'b0, 16'h0, "s036.x0");
    drain_all("s036.dx0");
    step(1'b1, 16'h0200, '0, 1'b0, 16'h0, "s036.x1");
    drain_all("s036.dx1");
    step(1'b1, 16'h5000, {8{16'h5000}}, 1'b0, 16'h0, "s036.b0");
    step(1'b1, 16'h5100, {8{16'h5100}}, 1'b0, 16'h0, "s036.b1");
    check("s036.write_b0", pmem_address, 16'h5000);
    step(1'b1, 16'h5200, {8{16'h5200}}, 1'b1, 16'h0, "s036.both");
    check("s036.not_empty", wb_empty, 1'b0);
    check("s036.not_full", wb_full, 1'b0);
    drain_all("s036.drain");
    check_order("s036", 2, 16'h5100, 16'h5200, 16'h0000);

    // Reset asserted in the middle of a WRITE with three entries held.
    do_reset("s037");
    step(1'b1, 16'h3000, '1, 1'b0, 16'h0, "s037.p0");
    step(1'b1, 16'h3100, '1, 1'b0, 16'h0, "s037.p1");
    step(1'b1, 16'h3200, '1, 1'b0, 16'h0, "s037.p2");
    check("s037.in_write", pmem_write, 1'b1);
    #2;
    do_reset("s037.mid");
    for (int i = 0; i < 6; i++)
      step(1'b0, 16'h0, '0, 1'($urandom_range(0, 1)), 16'h0, "s037.after");
    check("s037.no_write", pmem_write, 1'b0);

    // Forwarding: newest matching line wins.
    do_reset("s038");
    d1 = {4{32'h1111_0001}};
    d2 = {4{32'h2222_0002}};
    step(1'b1, 16'h2000, d1, 1'b0, 16'h200c, "s038.p1");
    step(1'b1, 16'h2008, d2, 1'b0, 16'h200c, "s038.p2");
`ifdef WB_FORWARD_EN
    check("s038.hit", lookup_hit, 1'b1);
    check("s038.data", lookup_data, d2);
`else
    check("s038.hit", lookup_hit, 1'b0);
    check("s038.data", lookup_data, '0);
`endif
    drain_all("s038.drain");

    // Randomized traffic over a small pool of lines so forwarding matches occur.
    do_reset("rnd");
    for (int i = 0; i < 400; i++) begin
      logic     p, r;
      lc3b_word a, la;
      p  = ($urandom_range(0, 99) < 45);
      r  = ($urandom_range(0, 99) < 40);
      a  = {8'h6a, 4'($urandom_range(0, 3)), 4'($urandom())};
      la = {8'h6a, 4'($urandom_range(0, 4)), 4'($urandom())};
      d2 = {$urandom(), $urandom(), $urandom(), $urandom()};
      step(p, a, d2, r, la, "rnd");
    end
    drain_all("rnd.drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_drain_buffer.md
WB_DRAIN_BUFFER -- requirements
Module: wb_drain_buffer

Interface
REQ-001 SHALL have parameter LINE_W, default 128, meaning cache line width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning entry count; legal value 4 only.
REQ-003 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have wb_push  input  1  cache requests enqueue of an evicted dirty line.
REQ-006 SHALL have wb_addr  input  16  byte address of the evicted line.
REQ-007 SHALL have wb_data  input  LINE_W  evicted line contents.
REQ-008 SHALL have wb_full  output  1  high when 4 entries are held.
REQ-009 SHALL have wb_empty  output  1  high when 0 entries are held.
REQ-010 SHALL have wb_overflow  output  1  sticky flag: push attempted while full.
REQ-011 SHALL have pmem_write  output  1  write request to physical memory.
REQ-012 SHALL have pmem_address  output  16  line address of the head entry.
REQ-013 SHALL have pmem_wdata  output  LINE_W  data of the head entry.
REQ-014 SHALL have pmem_resp  input  1  memory completed the current write.
REQ-015 SHALL have lookup_addr  input  16, lookup_hit  output  1, lookup_data  output  LINE_W: the forwarding port (see REQ-030).

Function
REQ-016 SHALL store entries in FIFO order; 2-bit head/tail pointers wrap 3->0; 3-bit count 0..4.
REQ-017 SHALL enqueue on a rising edge when wb_push=1 and wb_full=0; the entry is visible to the drain FSM the next cycle.
REQ-018 SHALL drop a push when wb_full=1 and set wb_overflow, which stays set until reset.
REQ-019 SHALL derive wb_full/wb_empty from the registered count only, never from same-cycle push/pop.
REQ-020 SHALL run the drain FSM with states IDLE and WRITE; IDLE->WRITE when count>0; WRITE->IDLE on pmem_resp=1.
REQ-021 SHALL drive pmem_write=1 only in WRITE; pmem_address and pmem_wdata hold head-entry values stable throughout WRITE.
REQ-022 SHALL force pmem_address[3:0]=0 (16-byte line alignment).
REQ-023 SHALL pop the head entry (head+1, count-1) on the edge where pmem_resp=1 in WRITE.
REQ-024 SHALL ignore pmem_resp in IDLE.
REQ-025 SHALL, on simultaneous push and pop, leave count unchanged and update both pointers; push is still refused if wb_full was already 1.
REQ-026 SHALL take a minimum of 2 cycles per drained entry (one IDLE cycle between writes).

Reset
REQ-027 SHALL, while rst_n=0, force state IDLE, pointers 0, count 0, wb_overflow 0, pmem_write 0, wb_empty 1, wb_full 0, lookup_hit 0.
REQ-028 SHALL abandon any in-flight write when reset asserts mid-WRITE; contents are discarded, and no pmem_write is asserted after reset until a new push.
REQ-029 SHALL leave entry data storage unreset; only valid state is reset.

Configuration
REQ-030 SHALL provide macro WB_FORWARD_EN: defined -> lookup_hit combinationally =1 when any held entry's addr[15:4] equals lookup_addr[15:4], newest match wins, lookup_data = that entry's data, head entry counts as held until popped; undefined -> lookup_hit tied 0, lookup_data tied 0, lookup_addr unused.

Structure
REQ-031 SHALL take lc3b_word (16-bit) and lc3b_c_line (128-bit) from package lc3b_types; DEPTH-independent state enum declared locally.
REQ-032 SHALL place entry storage (address + data, 4 entries, indexed write, two read ports) in sub-module wb_line_array.

Verification
REQ-033 SHALL: push addr 0x1234/data D0 on empty -> next cycle WRITE, pmem_address=0x1230, pmem_wdata=D0; pmem_resp after 3 cycles -> pop, wb_empty=1.
REQ-034 SHALL: 5 pushes, pmem_resp held 0 -> wb_full=1 after 4th, 5th dropped, wb_overflow=1, then drain order A0..A3 exactly.
REQ-035 SHALL: at count=4, pmem_resp=1 and wb_push=1 same edge -> push refused, count=3, wb_overflow=1.
REQ-036 SHALL: at count=2, push and pop same edge -> count stays 2, drain order preserved across pointer wrap 3->0.
REQ-037 SHALL: rst_n low mid-WRITE at count=3 -> pmem_write=0 immediately, wb_empty=1, no write issued after release.
REQ-038 SHALL: with WB_FORWARD_EN, push 0x2000/D1 then 0x2008/D2 -> lookup 0x200C gives hit=1, data=D2; without macro hit=0.
